// File: rtl/count_display.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-slot multiplexed 7-segment scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module count_display #(
    parameter logic [19:0] SCAN_TICKS = 20'd100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       bcd_valid
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [19:0] r_shift;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;
    logic        r_bcd_valid;

    logic [19:0] r_scan_cnt;
    logic [1:0]  r_idx;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;

    logic [18:0] w_adj;
    logic        w_tick;
    logic [1:0]  w_next_idx;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic [6:0]  w_seg_next;
    logic [3:0]  w_an_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Hundreds never exceeds 2 for an 8-bit input, so only tens/ones need the +3 correction.
    always_comb begin
        w_adj = r_shift[18:0];
        if (r_shift[11:8] >= 4'd5)
            w_adj[11:8] = r_shift[11:8] + 4'd3;
        if (r_shift[15:12] >= 4'd5)
            w_adj[15:12] = r_shift[15:12] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_hund      <= '0;
            r_tens      <= '0;
            r_ones      <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_shift   <= {12'd0, value};
                    r_bit_cnt <= '0;
                    r_state   <= CONVERT;
                end
                CONVERT: begin
                    r_shift   <= {w_adj, 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7)
                        r_state <= COMMIT;
                end
                COMMIT: begin
                    r_hund      <= r_shift[19:16];
                    r_tens      <= r_shift[15:12];
                    r_ones      <= r_shift[11:8];
                    r_bcd_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_tick     = (r_scan_cnt == SCAN_TICKS - 20'd1);
    assign w_next_idx = r_idx + 2'd1;

    always_comb begin
        w_digit   = r_ones;
        w_blank   = 1'b0;
        w_an_next = 4'b1110;
        case (w_next_idx)
            2'd0: begin
                w_digit   = r_ones;
                w_an_next = 4'b1110;
            end
            2'd1: begin
                w_digit   = r_tens;
                w_an_next = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank   = (r_hund == 4'd0) && (r_tens == 4'd0);
`endif
            end
            2'd2: begin
                w_digit   = r_hund;
                w_an_next = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank   = (r_hund == 4'd0);
`endif
            end
            default: begin
                w_blank   = 1'b1;
                w_an_next = 4'b0111;
            end
        endcase
        w_seg_next = w_blank ? 7'b1111111 : seg_decode(w_digit);
    end

    // Display regs are read before the same-edge COMMIT update lands, so a coinciding tick shows the old digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd3;
            r_an       <= 4'b1111;
            r_seg      <= 7'b1111111;
        end else if (w_tick) begin
            r_scan_cnt <= '0;
            r_idx      <= w_next_idx;
            r_an       <= w_an_next;
            r_seg      <= w_seg_next;
        end else begin
            r_scan_cnt <= r_scan_cnt + 20'd1;
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign bcd_valid = r_bcd_valid;

endmodule

// File: tb/tb_count_display.sv
// Scoreboard bench: SCAN_TICKS=4 instance for directed slot timing, SCAN_TICKS=1 instance for per-commit digit checks.
module tb_count_display;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] value;
    logic [6:0] seg4, seg1;
    logic [3:0] an4, an1;
    logic       bv4, bv1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_q[$];

    count_display #(.SCAN_TICKS(20'd4)) dut4 (
        .clk(clk), .rst_n(rst_n), .value(value),
        .seg(seg4), .an(an4), .bcd_valid(bv4)
    );

    count_display #(.SCAN_TICKS(20'd1)) dut1 (
        .clk(clk), .rst_n(rst_n), .value(value),
        .seg(seg1), .an(an1), .bcd_valid(bv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int slot);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (slot)
            0: return seg_of(o);
            1: return (BLANK && h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
            2: return (BLANK && h == 0) ? 7'b1111111 : seg_of(h);
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int slot_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: after each commit of the fast-scan instance, the next four slots show the new digits.
    initial begin
        int v, s;
        forever begin
            @(negedge clk);
            if (rst_n && bv1) begin
                if (exp_q.size() == 0) begin
                    chk("commit with empty scoreboard", 32'd1, 32'd0);
                end else begin
                    v = exp_q.pop_front();
                    repeat (4) begin
                        @(negedge clk);
                        s = slot_of(an1);
                        if (s < 0) chk("sb an one-hot", {28'd0, an1}, 32'hE);
                        else       chk($sformatf("sb v=%0d slot%0d", v, s), {25'd0, seg1}, {25'd0, exp_seg(v, s)});
                    end
                end
            end
        end
    end

    // Commit cadence: first pulse 10 cycles after reset release, then every 10 cycles.
    initial begin
        int last;
        last = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) last = -1;
            else if (bv4) begin
                if (last < 0) chk("first bcd_valid cycle", cyc, 10);
                else          chk("bcd_valid period", cyc - last, 10);
                last = cyc;
                chk("bcd_valid in step", {31'd0, bv1}, 32'd1);
            end
        end
    end

    initial begin
        int vecs[7] = '{0, 128, 99, 200, 9, 10, 100};
        rst_n = 1'b0;
        value = 8'd30;
        tick(3);
        chk("reset an4", {28'd0, an4}, 32'hF);
        chk("reset seg4", {25'd0, seg4}, 32'h7F);
        chk("reset bv4", {31'd0, bv4}, 32'd0);
        chk("reset an1", {28'd0, an1}, 32'hF);

        rst_n = 1'b1;
        exp_q.push_back(30);
        tick(1);
        chk("e1 an1", {28'd0, an1}, 32'hE);
        chk("e1 seg1", {25'd0, seg1}, {25'd0, exp_seg(0, 0)});
        chk("e1 an4", {28'd0, an4}, 32'hF);
        tick(1);
        chk("e2 an1", {28'd0, an1}, 32'hD);
        chk("e2 seg1", {25'd0, seg1}, {25'd0, exp_seg(0, 1)});
        tick(1);
        chk("e3 an1", {28'd0, an1}, 32'hB);
        chk("e3 seg1", {25'd0, seg1}, {25'd0, exp_seg(0, 2)});
        chk("e3 an4", {28'd0, an4}, 32'hF);
        tick(1);
        chk("e4 an1", {28'd0, an1}, 32'h7);
        chk("e4 seg1", {25'd0, seg1}, 32'h7F);
        chk("e4 an4 first tick", {28'd0, an4}, 32'hE);
        chk("e4 seg4", {25'd0, seg4}, {25'd0, exp_seg(0, 0)});
        tick(1);
        chk("e5 an1 wrap", {28'd0, an1}, 32'hE);
        tick(3);
        chk("e8 an4", {28'd0, an4}, 32'hD);
        chk("e8 seg4 pre-commit", {25'd0, seg4}, {25'd0, exp_seg(0, 1)});
        tick(2);
        exp_q.push_back(30);
        tick(2);
        chk("e12 an4", {28'd0, an4}, 32'hB);
        chk("e12 seg4 hund", {25'd0, seg4}, {25'd0, exp_seg(30, 2)});
        tick(1);
        chk("e13 an4 hold", {28'd0, an4}, 32'hB);
        tick(3);
        chk("e16 an4", {28'd0, an4}, 32'h7);
        chk("e16 seg4 blank", {25'd0, seg4}, 32'h7F);
        tick(4);
        chk("e20 an4", {28'd0, an4}, 32'hE);
        chk("e20 seg4 ones", {25'd0, seg4}, 32'h40);
        value = 8'd255;
        exp_q.push_back(255);
        tick(4);
        chk("e24 an4", {28'd0, an4}, 32'hD);
        chk("e24 seg4 tens", {25'd0, seg4}, 32'h30);
        tick(6);

        foreach (vecs[i]) begin
            value = vecs[i][7:0];
            exp_q.push_back(vecs[i]);
            tick(10);
        end

        // Value changes during the third CONVERT cycle must not affect this commit.
        value = 8'd7;
        exp_q.push_back(7);
        tick(3);
        value = 8'd8;
        tick(7);
        exp_q.push_back(8);
        tick(10);

        value = 8'd42;
        tick(6);
        rst_n = 1'b0;
        #1;
        chk("midconv reset an4", {28'd0, an4}, 32'hF);
        chk("midconv reset seg4", {25'd0, seg4}, 32'h7F);
        chk("midconv reset an1", {28'd0, an1}, 32'hF);
        chk("midconv reset bv1", {31'd0, bv1}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        exp_q.push_back(42);
        tick(1);
        chk("post-reset e1 seg1 zero", {25'd0, seg1}, {25'd0, exp_seg(0, 0)});
        tick(2);
        chk("post-reset e3 an4", {28'd0, an4}, 32'hF);
        tick(1);
        chk("post-reset e4 an4", {28'd0, an4}, 32'hE);
        chk("post-reset e4 seg4 zero", {25'd0, seg4}, {25'd0, exp_seg(0, 0)});
        tick(6);

        value = 8'd5;
        exp_q.push_back(5);
        tick(15);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
